// File: rtl/clock_set_ctrl.sv
// Time-set sequencer for an h/m/s counter: generates the count tick, runs the
// two-button edit procedure and emits a one-cycle load strobe with edited values.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal timekeeping, prescaler running, tick issued every div cycles
// EDIT_H | hour under edit, inc press bumps set_h
// EDIT_M | minute under edit, inc press bumps set_m
// EDIT_S | second under edit, inc press bumps set_s
// COMMIT | single cycle, set strobe high with stable set_h/m/s
module clock_set_ctrl #(
    parameter int max_h   = 24,
    parameter int max_m   = 60,
    parameter int max_s   = 60,
    parameter int div     = 50,
    parameter int timeout = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    output logic       tick,
    output logic       set,
    output logic [5:0] set_h,
    output logic [5:0] set_m,
    output logic [5:0] set_s,
    output logic [1:0] field
);

    localparam int PW = (div > 1) ? $clog2(div) : 1;
    localparam int IW = (timeout > 1) ? $clog2(timeout) : 1;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        EDIT_H = 3'd1,
        EDIT_M = 3'd2,
        EDIT_S = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            mode_prev_q, inc_prev_q;
    logic            tick_q, tick_d;
    logic            set_q, set_d;
    logic [5:0]      set_h_q, set_h_d;
    logic [5:0]      set_m_q, set_m_d;
    logic [5:0]      set_s_q, set_s_d;
    logic [1:0]      field_q, field_d;
    logic            mode_p, inc_p;

    function automatic logic [5:0] capture(input logic [5:0] v, input int m);
        return (int'(v) >= m) ? 6'd0 : v;
    endfunction

    function automatic logic [5:0] bump(input logic [5:0] v, input int m);
        return (int'(v) >= m - 1) ? 6'd0 : v + 6'd1;
    endfunction

    assign mode_p = btn_mode & ~mode_prev_q;
    assign inc_p  = btn_inc & ~inc_prev_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idle_d  = idle_q;
        tick_d  = 1'b0;
        set_h_d = set_h_q;
        set_m_d = set_m_q;
        set_s_d = set_s_q;

        case (state_q)
            RUN: begin
                if (mode_p) begin
                    state_d = EDIT_H;
                    presc_d = '0;
                    idle_d  = '0;
                    set_h_d = capture(cur_h, max_h);
                    set_m_d = capture(cur_m, max_m);
                    set_s_d = capture(cur_s, max_s);
                end else if (presc_q == PW'(div - 1)) begin
                    tick_d  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                presc_d = '0;
                if (inc_p) begin
                    case (state_q)
                        EDIT_H:  set_h_d = bump(set_h_q, max_h);
                        EDIT_M:  set_m_d = bump(set_m_q, max_m);
                        default: set_s_d = bump(set_s_q, max_s);
                    endcase
                end
                // increment and advance may coincide; both take effect on this edge
                if (mode_p) begin
                    case (state_q)
                        EDIT_H:  state_d = EDIT_M;
                        EDIT_M:  state_d = EDIT_S;
                        default: state_d = COMMIT;
                    endcase
                end
                if (mode_p || inc_p) begin
                    idle_d = '0;
                end else if (timeout > 0) begin
                    if (idle_q == IW'(timeout - 1)) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = RUN;
                presc_d = '0;
                idle_d  = '0;
            end
            default: begin
                state_d = RUN;
                presc_d = '0;
                idle_d  = '0;
            end
        endcase

        set_d = (state_d == COMMIT);
        case (state_d)
            EDIT_H:  field_d = 2'd1;
            EDIT_M:  field_d = 2'd2;
            EDIT_S:  field_d = 2'd3;
            default: field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            presc_q     <= '0;
            idle_q      <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            tick_q      <= 1'b0;
            set_q       <= 1'b0;
            set_h_q     <= '0;
            set_m_q     <= '0;
            set_s_q     <= '0;
            field_q     <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            idle_q      <= idle_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            tick_q      <= tick_d;
            set_q       <= set_d;
            set_h_q     <= set_h_d;
            set_m_q     <= set_m_d;
            set_s_q     <= set_s_d;
            field_q     <= field_d;
        end
    end

    assign tick  = tick_q;
    assign set   = set_q;
    assign set_h = set_h_q;
    assign set_m = set_m_q;
    assign set_s = set_s_q;
    assign field = field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: one instance with the idle timeout disabled,
// one with timeout=8, both with div=4 and driven from the same inputs.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] cur_h = '0, cur_m = '0, cur_s = '0;

    logic       tick, set;
    logic [5:0] set_h, set_m, set_s;
    logic [1:0] field;
    logic       tick_to, set_to;
    logic [5:0] set_h_to, set_m_to, set_s_to;
    logic [1:0] field_to;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(.max_h(24), .max_m(60), .max_s(60), .div(4), .timeout(0)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
        .tick(tick), .set(set), .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .field(field)
    );

    clock_set_ctrl #(.max_h(24), .max_m(60), .max_s(60), .div(4), .timeout(8)) dut_to (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
        .tick(tick_to), .set(set_to), .set_h(set_h_to), .set_m(set_m_to), .set_s(set_s_to),
        .field(field_to)
    );

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({tick, set, field} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: tick=%0b set=%0b field=%0d, expected 0/0/0", tick, set, field);
        end
        vectors++;
        if ({set_h, set_m, set_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_vals: %0d:%0d:%0d, expected 0:0:0", set_h, set_m, set_s);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            if (tick !== ((c % 4) == 0) || set !== 1'b0 || field !== 2'd0) begin
                bad++;
                $display("FAIL tick_cycle%0d: tick=%0b set=%0b field=%0d, expected tick=%0b set=0 field=0",
                         c, tick, set, field, ((c % 4) == 0));
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
    endtask

    task automatic test_edit_commit();
        int tick_seen;
        do_reset();
        cur_h = 6'd10; cur_m = 6'd59; cur_s = 6'd58;
        tick_seen = 0;
        btn_mode = 1'b1;
        step();
        vectors++;
        if (field !== 2'd1 || {set_h, set_m, set_s} !== {6'd10, 6'd59, 6'd58}) begin
            miscompares++;
            $display("FAIL capture: field=%0d set=%0d:%0d:%0d, expected 1 and 10:59:58",
                     field, set_h, set_m, set_s);
        end
        btn_mode = 1'b0;
        step();
        tick_seen += int'(tick);
        press_inc();
        tick_seen += int'(tick);
        press_inc();
        tick_seen += int'(tick);
        vectors++;
        if (set_h !== 6'd12) begin
            miscompares++;
            $display("FAIL inc_hour: set_h=%0d, expected 12", set_h);
        end
        btn_mode = 1'b1;
        step();
        vectors++;
        if (field !== 2'd2) begin
            miscompares++;
            $display("FAIL step_to_min: field=%0d, expected 2", field);
        end
        btn_mode = 1'b0;
        step();
        press_inc();
        tick_seen += int'(tick);
        vectors++;
        if (set_m !== 6'd0) begin
            miscompares++;
            $display("FAIL inc_min_wrap: set_m=%0d, expected 0", set_m);
        end
        btn_mode = 1'b1;
        step();
        tick_seen += int'(tick);
        vectors++;
        if (field !== 2'd3) begin
            miscompares++;
            $display("FAIL step_to_sec: field=%0d, expected 3", field);
        end
        btn_mode = 1'b0;
        step();
        tick_seen += int'(tick);
        vectors++;
        if (set !== 1'b0) begin
            miscompares++;
            $display("FAIL early_set: set=%0b, expected 0", set);
        end
        btn_mode = 1'b1;
        step();
        vectors++;
        if (set !== 1'b1 || tick !== 1'b0 || field !== 2'd0 ||
            {set_h, set_m, set_s} !== {6'd12, 6'd0, 6'd58}) begin
            miscompares++;
            $display("FAIL commit: set=%0b tick=%0b field=%0d vals=%0d:%0d:%0d, expected 1/0/0 12:0:58",
                     set, tick, field, set_h, set_m, set_s);
        end
        vectors++;
        if (tick_seen != 0) begin
            miscompares++;
            $display("FAIL tick_in_edit: %0d ticks seen, expected 0", tick_seen);
        end
        btn_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            vectors++;
            if (tick !== (k == 5) || set !== 1'b0) begin
                miscompares++;
                $display("FAIL post_commit%0d: tick=%0b set=%0b, expected tick=%0b set=0",
                         k, tick, set, (k == 5));
            end
        end
    endtask

    task automatic test_wrap_hold_same_cycle();
        do_reset();
        cur_h = 6'd23; cur_m = 6'd5; cur_s = 6'd0;
        press_mode();
        btn_inc = 1'b1;
        step();
        vectors++;
        if (set_h !== 6'd0) begin
            miscompares++;
            $display("FAIL hour_wrap: set_h=%0d, expected 0", set_h);
        end
        for (int k = 0; k < 9; k++) step();
        btn_inc = 1'b0;
        step();
        vectors++;
        if (set_h !== 6'd0 || field !== 2'd1) begin
            miscompares++;
            $display("FAIL held_inc: set_h=%0d field=%0d, expected 0 and 1", set_h, field);
        end
        press_mode();
        btn_inc  = 1'b1;
        btn_mode = 1'b1;
        step();
        vectors++;
        if (set_m !== 6'd6 || field !== 2'd3) begin
            miscompares++;
            $display("FAIL same_cycle: set_m=%0d field=%0d, expected 6 and 3", set_m, field);
        end
        btn_inc  = 1'b0;
        btn_mode = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int set_seen;
        set_seen = 0;
        do_reset();
        cur_h = 6'd7; cur_m = 6'd8; cur_s = 6'd9;
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            set_seen += int'(set_to);
            vectors++;
            if (field_to !== ((k < 8) ? 2'd1 : 2'd0)) begin
                miscompares++;
                $display("FAIL timeout_field%0d: field=%0d, expected %0d", k, field_to, (k < 8) ? 1 : 0);
            end
        end
        vectors++;
        if ({set_h_to, set_m_to, set_s_to} !== {6'd7, 6'd8, 6'd9}) begin
            miscompares++;
            $display("FAIL timeout_keep: %0d:%0d:%0d, expected 7:8:9", set_h_to, set_m_to, set_s_to);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            set_seen += int'(set_to);
            vectors++;
            if (tick_to !== (k == 4)) begin
                miscompares++;
                $display("FAIL timeout_tick%0d: tick=%0b, expected %0b", k, tick_to, (k == 4));
            end
        end
        vectors++;
        if (set_seen != 0) begin
            miscompares++;
            $display("FAIL timeout_set: %0d set pulses, expected 0", set_seen);
        end
    endtask

    task automatic test_reset_mid_edit();
        do_reset();
        cur_h = 6'd10; cur_m = 6'd20; cur_s = 6'd30;
        press_mode();
        press_mode();
        press_mode();
        vectors++;
        if (field !== 2'd3 || set_s !== 6'd30) begin
            miscompares++;
            $display("FAIL pre_reset: field=%0d set_s=%0d, expected 3 and 30", field, set_s);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({tick, set, field} !== 4'b0 || {set_h, set_m, set_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL mid_reset: tick=%0b set=%0b field=%0d vals=%0d:%0d:%0d, expected all 0",
                     tick, set, field, set_h, set_m, set_s);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (tick !== (k == 4) || set !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_presc%0d: tick=%0b set=%0b, expected tick=%0b set=0",
                         k, tick, set, (k == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_edit_commit();
        test_wrap_hold_same_cycle();
        test_timeout();
        test_reset_mid_edit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
